branch_resolve_predict: RTL and testbench

Parametrised successor to the single-opcode branch decision logic. It resolves the full MIPS conditional-branch set (beq, bne, blez, bgtz, bltz, bgez) from ALU flags and keeps a direct-mapped table of 2-bit saturating counters (BHT) that predicts fetch-stage branches. At resolve time it compares the actual outcome with the prediction that travelled with the instruction, then raises a registered mispredict/flush pulse. It also keeps saturating branch and mispredict statistics counters.

---
 rtl/branch_resolve_predict.sv | 108 ++++++++++
 tb/tb_branch_resolve_predict.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_predict.sv
// rtl/branch_resolve_predict.sv - MIPS branch resolve with 2-bit BHT prediction and stats
module branch_resolve_predict #(
  parameter int          PC_W      = 32,
  parameter int          BHT_DEPTH = 64,
  parameter logic [1:0]  CTR_INIT  = 2'b01,
  parameter int          STAT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PC_W-1:0]   lookup_pc,
  output logic              predict_taken,
  input  logic              res_valid,
  input  logic [PC_W-1:0]   res_pc,
  input  logic [5:0]        opcode,
  input  logic [4:0]        rt_field,
  input  logic              zero,
  input  logic              neg,
  input  logic              res_pred_taken,
  output logic              branch_taken,
  output logic              is_branch,
  output logic              mispredict,
  output logic              flush,
  output logic [STAT_W-1:0] branch_count,
  output logic [STAT_W-1:0] mispredict_count
);

  localparam int IDX_W = $clog2(BHT_DEPTH);

  logic [1:0]       bht [BHT_DEPTH];
  logic [IDX_W-1:0] lookup_idx;
  logic [IDX_W-1:0] res_idx;
  logic             cond;
  logic             update;
  logic             miss;
  logic             mispredict_q;

  // Word-aligned low bits and bits above the index do not select an entry.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{lookup_pc[PC_W-1:IDX_W+2], lookup_pc[1:0],
                            res_pc[PC_W-1:IDX_W+2], res_pc[1:0]};

  assign lookup_idx    = lookup_pc[IDX_W+1:2];
  assign res_idx       = res_pc[IDX_W+1:2];
  assign predict_taken = bht[lookup_idx][1];

  always_comb begin
    is_branch = 1'b0;
    cond      = 1'b0;
    case (opcode)
      6'b000100: begin is_branch = 1'b1; cond = zero;          end
      6'b000101: begin is_branch = 1'b1; cond = ~zero;         end
      6'b000110: begin is_branch = 1'b1; cond = neg | zero;    end
      6'b000111: begin is_branch = 1'b1; cond = ~neg & ~zero;  end
      6'b000001: begin
        if (rt_field == 5'b00000) begin
          is_branch = 1'b1;
          cond      = neg;
        end else if (rt_field == 5'b00001) begin
          is_branch = 1'b1;
          cond      = ~neg;
        end
      end
      default: begin
        is_branch = 1'b0;
        cond      = 1'b0;
      end
    endcase
  end

  assign branch_taken = res_valid & cond;
  assign update       = res_valid & is_branch;
  assign miss         = update & (branch_taken != res_pred_taken);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BHT_DEPTH; i++) begin
        bht[i] <= CTR_INIT;
      end
    end else if (update) begin
      if (branch_taken) begin
        if (bht[res_idx] != 2'b11) bht[res_idx] <= bht[res_idx] + 2'd1;
      end else begin
        if (bht[res_idx] != 2'b00) bht[res_idx] <= bht[res_idx] - 2'd1;
      end
    end
  end

  // Statistics hold at all-ones instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mispredict_q     <= 1'b0;
      branch_count     <= '0;
      mispredict_count <= '0;
    end else begin
      mispredict_q <= miss;
      if (update && (branch_count != {STAT_W{1'b1}})) begin
        branch_count <= branch_count + 1'b1;
      end
      if (miss && (mispredict_count != {STAT_W{1'b1}})) begin
        mispredict_count <= mispredict_count + 1'b1;
      end
    end
  end

  assign mispredict = mispredict_q;
  assign flush      = mispredict_q;

endmodule

// File: tb/tb_branch_resolve_predict.sv
// tb/tb_branch_resolve_predict.sv - randomized model-checked bench for branch_resolve_predict
module tb_branch_resolve_predict;

  localparam int PC_W   = 32;
  localparam int DEPTH  = 64;
  localparam int STAT_W = 4;
  localparam int SMAX   = 15;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [PC_W-1:0]   lookup_pc = '0;
  logic              predict_taken;
  logic              res_valid = 1'b0;
  logic [PC_W-1:0]   res_pc = '0;
  logic [5:0]        opcode = '0;
  logic [4:0]        rt_field = '0;
  logic              zero = 1'b0;
  logic              neg = 1'b0;
  logic              res_pred_taken = 1'b0;
  logic              branch_taken;
  logic              is_branch;
  logic              mispredict;
  logic              flush;
  logic [STAT_W-1:0] branch_count;
  logic [STAT_W-1:0] mispredict_count;

  int checks = 0;
  int failures = 0;

  int m_ctr [DEPTH];
  int m_bc;
  int m_mc;
  int m_misp;

  branch_resolve_predict #(
    .PC_W(PC_W), .BHT_DEPTH(DEPTH), .CTR_INIT(2'b01), .STAT_W(STAT_W)
  ) dut (
    .clk(clk), .rst(rst), .lookup_pc(lookup_pc), .predict_taken(predict_taken),
    .res_valid(res_valid), .res_pc(res_pc), .opcode(opcode), .rt_field(rt_field),
    .zero(zero), .neg(neg), .res_pred_taken(res_pred_taken),
    .branch_taken(branch_taken), .is_branch(is_branch), .mispredict(mispredict),
    .flush(flush), .branch_count(branch_count), .mispredict_count(mispredict_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic int idx_of(input logic [PC_W-1:0] pc);
    return int'((pc / 4) % DEPTH);
  endfunction

  // Returns 2 bits: {is a branch, condition holds}.
  function automatic logic [1:0] m_decode(input int op, input int rt, input logic z, input logic n);
    if (op == 4) return {1'b1, z};
    if (op == 5) return {1'b1, !z};
    if (op == 6) return {1'b1, n || z};
    if (op == 7) return {1'b1, !n && !z};
    if (op == 1 && rt == 0) return {1'b1, n};
    if (op == 1 && rt == 1) return {1'b1, !n};
    return 2'b00;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_ctr[i] = 1;
    m_bc = 0;
    m_mc = 0;
    m_misp = 0;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      model_reset();
    end else begin
      logic [1:0] d;
      int i;
      d = m_decode(int'(opcode), int'(rt_field), zero, neg);
      m_misp = 0;
      if (res_valid && d[1]) begin
        i = idx_of(res_pc);
        if (d[0]) m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
        else      m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
        m_bc = (m_bc < SMAX) ? m_bc + 1 : SMAX;
        if (d[0] != res_pred_taken) begin
          m_misp = 1;
          m_mc = (m_mc < SMAX) ? m_mc + 1 : SMAX;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      logic [1:0] d;
      d = m_decode(int'(opcode), int'(rt_field), zero, neg);
      chk("predict_taken", int'(predict_taken), (m_ctr[idx_of(lookup_pc)] >= 2) ? 1 : 0);
      chk("is_branch", int'(is_branch), int'(d[1]));
      chk("branch_taken", int'(branch_taken), (res_valid && d[1] && d[0]) ? 1 : 0);
      chk("mispredict", int'(mispredict), m_misp);
      chk("flush", int'(flush), m_misp);
      chk("branch_count", int'(branch_count), m_bc);
      chk("mispredict_count", int'(mispredict_count), m_mc);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input logic v, input logic [PC_W-1:0] pc, input int op, input int rt,
                       input logic z, input logic n, input logic pred);
    res_valid = v; res_pc = pc; opcode = 6'(op); rt_field = 5'(rt);
    zero = z; neg = n; res_pred_taken = pred;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 rst = 1'b1;
    #4 rst = 1'b0;
    #1;
  endtask

  int op_tab [8] = '{4, 5, 6, 7, 1, 1, 1, 0};
  int rt_tab [8] = '{0, 0, 0, 0, 0, 1, 2, 0};
  logic z_tab [8] = '{1, 1, 0, 0, 0, 0, 0, 1};
  logic n_tab [8] = '{0, 0, 0, 0, 1, 1, 1, 1};
  int isb_tab [8] = '{1, 1, 1, 1, 1, 1, 0, 0};
  int tk_tab [8]  = '{1, 0, 0, 1, 1, 0, 0, 0};

  initial begin
    model_reset();
    #12 rst = 1'b0;
    #1;

    // Reset state and fresh prediction
    lookup_pc = 32'h40;
    #1 chk("reset_predict_0x40", int'(predict_taken), 0);
    chk("reset_branch_count", int'(branch_count), 0);
    chk("reset_mispredict", int'(mispredict), 0);

    // Mispredict pulse and counters
    tick();
    apply(1, 32'h200, 4, 0, 1, 0, 0);
    #1 chk("misp_taken_comb", int'(branch_taken), 1);
    tick();
    chk("misp_pulse", int'(mispredict), 1);
    chk("misp_flush", int'(flush), 1);
    chk("misp_count", int'(mispredict_count), 1);
    chk("misp_branch_count", int'(branch_count), 1);
    apply(1, 32'h200, 4, 0, 1, 0, 1);
    tick();
    chk("correct_no_pulse", int'(mispredict), 0);
    apply(0, 32'h200, 4, 0, 1, 0, 0);
    tick();
    chk("idle_no_pulse", int'(mispredict), 0);
    chk("misp_count_hold", int'(mispredict_count), 1);

    // Decode sweep
    for (int k = 0; k < 8; k++) begin
      apply(1, 32'h300, op_tab[k], rt_tab[k], z_tab[k], n_tab[k], 0);
      #1;
      chk($sformatf("decode_isb_%0d", k), int'(is_branch), isb_tab[k]);
      chk($sformatf("decode_taken_%0d", k), int'(branch_taken), tk_tab[k]);
      tick();
    end
    apply(0, 32'h300, 4, 0, 1, 0, 0);
    #1 chk("invalid_not_taken", int'(branch_taken), 0);

    // Saturation at 0x100
    do_reset();
    lookup_pc = 32'h100;
    for (int k = 0; k < 4; k++) begin apply(1, 32'h100, 4, 0, 1, 0, 0); tick(); end
    chk("sat_up_predict", int'(predict_taken), 1);
    apply(1, 32'h100, 4, 0, 0, 0, 1); tick();
    chk("one_down_still_taken", int'(predict_taken), 1);
    for (int k = 0; k < 2; k++) tick();
    chk("three_down_not_taken", int'(predict_taken), 0);
    for (int k = 0; k < 2; k++) tick();
    chk("five_down_stays_0", int'(predict_taken), 0);
    apply(1, 32'h100, 4, 0, 1, 0, 0); tick();
    chk("from_0_one_up", int'(predict_taken), 0);
    apply(0, 0, 0, 0, 0, 0, 0);

    // Aliasing
    do_reset();
    for (int k = 0; k < 2; k++) begin apply(1, 32'h0, 5, 0, 0, 0, 0); tick(); end
    apply(0, 0, 0, 0, 0, 0, 0);
    lookup_pc = 32'h100;
    #1 chk("alias_0x100", int'(predict_taken), 1);
    lookup_pc = 32'h004;
    #1 chk("neighbour_0x004", int'(predict_taken), 0);
    tick();

    // Same-cycle lookup/update on index 5, then stat saturation
    do_reset();
    lookup_pc = 32'h14;
    apply(1, 32'h14, 7, 0, 0, 0, 0);
    #1 chk("same_cycle_old", int'(predict_taken), 0);
    tick();
    apply(0, 32'h14, 7, 0, 0, 0, 0);
    #1 chk("next_cycle_new", int'(predict_taken), 1);
    apply(1, 32'h18, 6, 0, 0, 1, 0);
    for (int k = 0; k < 20; k++) tick();
    chk("branch_count_sat", int'(branch_count), 15);
    chk("mispredict_count_sat", int'(mispredict_count), 15);

    // Random stimulus with occasional resets
    for (int c = 0; c < 3000; c++) begin
      int sel;
      sel = $urandom_range(0, 7);
      apply($urandom_range(0, 9) < 8, 32'($urandom_range(0, 255)) << 2,
            (sel < 6) ? op_tab[sel] : $urandom_range(0, 63), $urandom_range(0, 2),
            1'($urandom), 1'($urandom), 1'($urandom));
      lookup_pc = ($urandom_range(0, 1) == 1) ? res_pc : 32'($urandom);
      tick();
      if (c % 700 == 699) do_reset();
    end

    // Asynchronous reset mid-run after training
    apply(1, 32'h14, 4, 0, 1, 0, 0);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("async_branch_count", int'(branch_count), 0);
    chk("async_mispredict_count", int'(mispredict_count), 0);
    chk("async_mispredict", int'(mispredict), 0);
    chk("async_comb_follows", int'(branch_taken), 1);
    for (int i = 0; i < DEPTH; i++) begin
      lookup_pc = 32'(i * 4);
      #1 chk($sformatf("async_entry_%0d", i), int'(predict_taken), 0);
    end
    rst = 1'b0;
    apply(0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
